// File: rtl/reel_round_ctrl.sv
// Round sequencer for the three-reel guessing game: spins and locks the reels, times the
// guess window in BCD seconds and judges the guesses. Optional macro: REEL_CTRL_AUTOCHECK_EN.
module reel_round_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SPIN_SECS     = 2,
    parameter int ROUND_SECS    = 60,
    parameter int FLASH_SECS    = 5
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       start,
    input  logic       submit,
    input  logic [8:0] rand_in,
    input  logic [5:0] guess,
    output logic       lfsr_en,
    output logic [5:0] reel_sym,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic       tick,
    output logic [2:0] state_o,
    output logic       win,
    output logic       lose,
    output logic       flash
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPIN  = 3'd1,
        S_LOCK  = 3'd2,
        S_GUESS = 3'd3,
        S_CHECK = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam int PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int MAXS = (SPIN_SECS > FLASH_SECS) ? SPIN_SECS : FLASH_SECS;
    localparam int CW   = (MAXS > 1) ? $clog2(MAXS + 1) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] SPIN_LAST  = CW'(SPIN_SECS - 1);
    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_SECS - 1);
    localparam logic [3:0]    RT_ONES    = 4'(ROUND_SECS % 10);
    localparam logic [3:0]    RT_TENS    = 4'(ROUND_SECS / 10);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] secs_q, secs_d;
    logic [1:0]    lock_k_q, lock_k_d;
    logic [5:0]    reel_q, reel_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          lfsr_en_q, lfsr_en_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic          flash_q, flash_d;

    logic          timed;
    logic          tick_int;
    logic          match;
    logic          auto_hit;
    logic [3:0]    ones_inc;
    logic [3:0]    tens_inc;
    logic          round_done;

    function automatic logic [1:0] mod3(input logic [2:0] r);
        case (r)
            3'd0, 3'd3, 3'd6: mod3 = 2'd0;
            3'd1, 3'd4, 3'd7: mod3 = 2'd1;
            default:          mod3 = 2'd2;
        endcase
    endfunction

    // CHECK is a single cycle and IDLE holds the prescaler, so neither produces ticks.
    assign timed    = (state_q == S_SPIN) || (state_q == S_LOCK) || (state_q == S_GUESS) ||
                      (state_q == S_WIN)  || (state_q == S_LOSE);
    assign tick_int = timed && (presc_q == '0);

    // Locked symbols never exceed 2, so a guess of 3 cannot match.
    assign match = (guess[1:0] == reel_q[1:0]) &&
                   (guess[3:2] == reel_q[3:2]) &&
                   (guess[5:4] == reel_q[5:4]);

`ifdef REEL_CTRL_AUTOCHECK_EN
    assign auto_hit = match;
`else
    assign auto_hit = 1'b0;
`endif

    assign ones_inc   = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
    assign tens_inc   = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
    assign round_done = ({tens_inc, ones_inc} == {RT_TENS, RT_ONES});

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        secs_d   = secs_q;
        lock_k_d = lock_k_q;
        reel_d   = reel_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        flash_d  = flash_q;

        if (!timed || tick_int) begin
            presc_d = PRESC_MAX;
        end else begin
            presc_d = presc_q - PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SPIN;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    reel_d  = 6'd0;
                end
            end
            S_SPIN: begin
                if (tick_int) begin
                    if (secs_q == SPIN_LAST) begin
                        state_d  = S_LOCK;
                        lock_k_d = 2'd0;
                    end else begin
                        secs_d = secs_q + CW'(1);
                    end
                end
            end
            S_LOCK: begin
                if (tick_int) begin
                    case (lock_k_q)
                        2'd0:    reel_d[1:0] = mod3(rand_in[2:0]);
                        2'd1:    reel_d[3:2] = mod3(rand_in[5:3]);
                        default: reel_d[5:4] = mod3(rand_in[8:6]);
                    endcase
                    if (lock_k_q == 2'd2) begin
                        state_d  = S_GUESS;
                        lock_k_d = 2'd0;
                    end else begin
                        lock_k_d = lock_k_q + 2'd1;
                    end
                end
            end
            S_GUESS: begin
                if (tick_int) begin
                    ones_d = ones_inc;
                    tens_d = tens_inc;
                end
                // A submit landing on the final tick still gets judged.
                if (submit || auto_hit) begin
                    state_d = S_CHECK;
                end else if (tick_int && round_done) begin
                    state_d = S_LOSE;
                end
            end
            S_CHECK: begin
                state_d = match ? S_WIN : S_LOSE;
            end
            S_WIN, S_LOSE: begin
                if (tick_int) begin
                    flash_d = ~flash_q;
                    if (secs_q == FLASH_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        secs_d = secs_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            presc_d = PRESC_MAX;
            secs_d  = '0;
        end
        if ((state_d != S_WIN) && (state_d != S_LOSE)) begin
            flash_d = 1'b0;
        end

        lfsr_en_d = (state_d == S_SPIN) || (state_d == S_LOCK);
        win_d     = (state_d == S_WIN);
        lose_d    = (state_d == S_LOSE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            secs_q    <= '0;
            lock_k_q  <= 2'd0;
            reel_q    <= 6'd0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            lfsr_en_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            flash_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            secs_q    <= secs_d;
            lock_k_q  <= lock_k_d;
            reel_q    <= reel_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            lfsr_en_q <= lfsr_en_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            flash_q   <= flash_d;
        end
    end

    assign tick     = tick_int;
    assign state_o  = state_q;
    assign lfsr_en  = lfsr_en_q;
    assign reel_sym = reel_q;
    assign sec_ones = ones_q;
    assign sec_tens = tens_q;
    assign win      = win_q;
    assign lose     = lose_q;
    assign flash    = flash_q;

endmodule

// File: tb/tb_reel_round_ctrl.sv
// Bench for reel_round_ctrl: directed rounds plus randomized rounds against a timeline
// model of the game (spin/lock/guess/flash phases derived from the second counts).
module tb_reel_round_ctrl;

    localparam int TPS        = 4;
    localparam int SPIN_SECS  = 2;
    localparam int ROUND_SECS = 3;
    localparam int FLASH_SECS = 2;
`ifdef REEL_CTRL_AUTOCHECK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       reset_b;
    logic       start;
    logic       submit;
    logic [8:0] rand_in;
    logic [5:0] guess;
    logic       lfsr_en;
    logic [5:0] reel_sym;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic       tick;
    logic [2:0] state_o;
    logic       win;
    logic       lose;
    logic       flash;

    int n_cmp = 0;
    int n_bad = 0;

    reel_round_ctrl #(
        .TICKS_PER_SEC(TPS),
        .SPIN_SECS    (SPIN_SECS),
        .ROUND_SECS   (ROUND_SECS),
        .FLASH_SECS   (FLASH_SECS)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .start   (start),
        .submit  (submit),
        .rand_in (rand_in),
        .guess   (guess),
        .lfsr_en (lfsr_en),
        .reel_sym(reel_sym),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .tick    (tick),
        .state_o (state_o),
        .win     (win),
        .lose    (lose),
        .flash   (flash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state_o), 0);
        chk({tag, "_lfsr"}, 32'(lfsr_en), 0);
        chk({tag, "_reel"}, 32'(reel_sym), 0);
        chk({tag, "_sec"}, 32'({sec_tens, sec_ones}), 0);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_win"}, 32'(win), 0);
        chk({tag, "_lose"}, 32'(lose), 0);
        chk({tag, "_flash"}, 32'(flash), 0);
    endtask

    // gmode: 0 = guesses equal the locked symbols, 1 = all 3s, other = random.
    // sub_m / start_m: guess-window cycle at which submit / start is pulsed (out of range = never).
    task automatic run_round(input int gmode, input int sub_m, input int start_m,
                             input bit rfixed, input logic [8:0] rfix);
        logic [5:0] es;
        logic [5:0] g;
        logic [8:0] r;
        int k;
        int mx;
        int sec_fin;
        int outc;
        bit via_chk;
        bit hit;
        es = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < (SPIN_SECS + 3) * TPS; n++) begin
            r = rfixed ? rfix : 9'($urandom_range(0, 511));
            rand_in = r;
            submit = 1'($urandom_range(0, 1));
            chk("run_state", 32'(state_o), (n < SPIN_SECS * TPS) ? 1 : 2);
            chk("run_lfsr_en", 32'(lfsr_en), 1);
            chk("run_tick", 32'(tick), ((n + 1) % TPS == 0) ? 1 : 0);
            chk("run_sec_cleared", 32'({sec_tens, sec_ones}), 0);
            if (n >= SPIN_SECS * TPS && (n + 1) % TPS == 0) begin
                k = (n - SPIN_SECS * TPS) / TPS;
                es[2 * k +: 2] = 2'(r[3 * k +: 3] % 3);
            end
            step();
        end
        submit = 1'b0;

        case (gmode)
            0:       g = es;
            1:       g = 6'b111111;
            default: g = 6'($urandom_range(0, 63));
        endcase
        guess = g;
        hit = (g == es);
        mx = ROUND_SECS * TPS - 1;
        via_chk = 1'b0;
        for (int m = 0; m < ROUND_SECS * TPS; m++) begin
            if (m == sub_m || (AUTO && hit)) begin
                mx = m;
                via_chk = 1'b1;
                break;
            end
        end

        for (int m = 0; m <= mx; m++) begin
            submit = (m == sub_m);
            start = (m == start_m);
            chk("guess_state", 32'(state_o), 3);
            chk("guess_lfsr_en", 32'(lfsr_en), 0);
            chk("guess_sec", 32'({sec_tens, sec_ones}), 32'(bcd(m / TPS)));
            chk("guess_reel", 32'(reel_sym), 32'(es));
            chk("guess_tick", 32'(tick), ((m + 1) % TPS == 0) ? 1 : 0);
            chk("guess_status", 32'({win, lose, flash}), 0);
            step();
        end
        submit = 1'b0;
        start = 1'b0;
        sec_fin = (mx + 1) / TPS;

        if (via_chk) begin
            chk("check_state", 32'(state_o), 4);
            chk("check_tick", 32'(tick), 0);
            chk("check_sec", 32'({sec_tens, sec_ones}), 32'(bcd(sec_fin)));
            step();
        end
        outc = (via_chk && hit) ? 5 : 6;

        for (int w = 0; w < FLASH_SECS * TPS; w++) begin
            start = 1'($urandom_range(0, 1));
            submit = 1'($urandom_range(0, 1));
            chk("end_state", 32'(state_o), 32'(outc));
            chk("end_win", 32'(win), (outc == 5) ? 1 : 0);
            chk("end_lose", 32'(lose), (outc == 6) ? 1 : 0);
            chk("end_flash", 32'(flash), (w / TPS) % 2);
            chk("end_tick", 32'(tick), ((w + 1) % TPS == 0) ? 1 : 0);
            chk("end_sec", 32'({sec_tens, sec_ones}), 32'(bcd(sec_fin)));
            chk("end_reel", 32'(reel_sym), 32'(es));
            step();
        end
        start = 1'b0;
        submit = 1'b0;

        chk("idle_state", 32'(state_o), 0);
        chk("idle_status", 32'({win, lose, flash, lfsr_en, tick}), 0);
        chk("idle_reel_held", 32'(reel_sym), 32'(es));
        chk("idle_sec_held", 32'({sec_tens, sec_ones}), 32'(bcd(sec_fin)));
        step();
        chk("idle_stays", 32'(state_o), 0);
        guess = 6'b111111;
    endtask

    initial begin
        reset_b = 1'b0;
        start   = 1'b0;
        submit  = 1'b0;
        rand_in = 9'd0;
        guess   = 6'b111111;
        repeat (2) step();
        chk_all_zero("reset");
        reset_b = 1'b1;
        repeat (3) step();
        chk("idle_after_reset", 32'(state_o), 0);
        chk("idle_no_tick", 32'(tick), 0);

        // Fixed reel values: expect symbols {1,2,0}, then a matching submit for a win.
        run_round(0, 5, -1, 1'b1, 9'b111_101_011);
        chk("fixed_reel_sym", 32'(reel_sym), 32'(6'b01_10_00));

        // Asynchronous reset in the middle of LOCK, with start held during reset.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) begin
            rand_in = 9'($urandom_range(0, 511));
            step();
        end
        chk("pre_reset_lock", 32'(state_o), 2);
        #2 reset_b = 1'b0;
        #1;
        chk_all_zero("async_reset");
        start = 1'b1;
        repeat (3) step();
        chk("start_during_reset", 32'(state_o), 0);
        chk("lfsr_during_reset", 32'(lfsr_en), 0);
        start = 1'b0;
        #2 reset_b = 1'b1;
        repeat (2) step();
        chk("idle_after_release", 32'(state_o), 0);
        chk("tick_after_release", 32'(tick), 0);

        // Timeout, losing submit, submit on the final tick with a stray start, no submit.
        run_round(1, 99, -1, 1'b0, 9'd0);
        run_round(1, 2, -1, 1'b0, 9'd0);
        run_round(0, ROUND_SECS * TPS - 1, 5, 1'b0, 9'd0);
        run_round(0, 99, -1, 1'b0, 9'd0);

        for (int i = 0; i < 8; i++) begin
            run_round($urandom_range(0, 1) * 2, $urandom_range(0, 14),
                      $urandom_range(0, 14), 1'b0, 9'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
